// File: rtl/uart_rx_capture.sv
// uart_rx_capture: UART receiver with glitch rejection, framing/overflow flags and a FWFT character FIFO.
// Define UART_RX_CAPTURE_PARITY_EN to add an even-parity bit per character, reported on rd_perr.
module uart_rx_capture #(
    parameter int CLKS_PER_BIT = 25,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_ferr,
    output logic                          rd_perr,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_BITS + 2;

`ifdef UART_RX_CAPTURE_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

    state_t               state, state_n;
    logic                 rx_meta, rxs;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 full_bit, half_bit, push, clr_cnt;
    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wp, rp;
    logic                 full, pop, wr;

    assign full_bit = cnt == CW'(CLKS_PER_BIT - 1);
    assign half_bit = cnt == CW'(CLKS_PER_BIT / 2 - 1);
    assign clr_cnt  = state_n != state || full_bit || state == IDLE || state == BRK;

    always_comb begin
        state_n = state;
        push    = 1'b0;
        case (state)
            IDLE:   state_n = rxs ? IDLE : START;
            START:  if (half_bit) state_n = rxs ? IDLE : DATA;
`ifdef UART_RX_CAPTURE_PARITY_EN
            DATA:   if (full_bit && idx == IW'(DATA_BITS - 1)) state_n = PARITY;
            PARITY: if (full_bit) state_n = STOP;
`else
            DATA:   if (full_bit && idx == IW'(DATA_BITS - 1)) state_n = STOP;
`endif
            STOP: begin
                push    = full_bit;
                state_n = full_bit ? (rxs ? IDLE : BRK) : STOP;
            end
            BRK:    state_n = rxs ? IDLE : BRK;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
            state   <= state_n;
            cnt     <= clr_cnt ? '0 : cnt + 1'b1;
            if (state == START)
                idx <= '0;
            if (state == DATA && full_bit) begin
                shreg <= {rxs, shreg[DATA_BITS-1:1]};
                idx   <= idx + 1'b1;
            end
        end
    end

`ifdef UART_RX_CAPTURE_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)
            perr <= 1'b0;
        else if (state == PARITY && full_bit)
            perr <= ^shreg ^ rxs;
    end
`else
    assign perr = 1'b0;
`endif

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign full     = level == LW'(FIFO_DEPTH);
    assign rd_valid = level != '0;
    assign pop      = rd_valid && rd_ready;
    assign wr       = push && (!full || pop);
    assign {rd_perr, rd_ferr, rd_data} = rd_valid ? mem[rp] : '0;

    always_ff @(posedge clk) begin
        if (wr && !rst)
            mem[wp] <= {perr, ~rxs, shreg};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            wp       <= wr ? wp + 1'b1 : wp;
            rp       <= pop ? rp + 1'b1 : rp;
            level    <= level + LW'(wr) - LW'(pop);
            overflow <= (push && full && !pop) || (overflow && !clr_overflow);
        end
    end
endmodule

// File: tb/tb_uart_rx_capture.sv
// tb_uart_rx_capture: directed vector table plus hand-written latency, glitch, break and overflow sequences.
module tb_uart_rx_capture;
    localparam int C = 16;
    localparam int D = 8;
    localparam int H = C / 2;
`ifdef UART_RX_CAPTURE_PARITY_EN
    localparam int STOP_EDGE = 3 + H + (D + 2) * C;
`else
    localparam int STOP_EDGE = 3 + H + (D + 1) * C;
`endif

    logic         clk = 1'b0;
    logic         rst, rxd, rd_ready, clr_overflow;
    logic         rd_valid, rd_ferr, rd_perr, overflow;
    logic [D-1:0] rd_data;
    logic [2:0]   level;
    int           checks = 0;
    int           errors = 0;

    uart_rx_capture #(.CLKS_PER_BIT(C), .DATA_BITS(D), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_ferr(rd_ferr), .rd_perr(rd_perr), .overflow(overflow),
        .clr_overflow(clr_overflow), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       par;
        logic [7:0] exp_d;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;
    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_char(input logic [7:0] d, input logic stop, input logic par);
        rxd = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < D; i++) begin
            rxd = d[i];
            repeat (C) tick();
        end
`ifdef UART_RX_CAPTURE_PARITY_EN
        rxd = par;
        repeat (C) tick();
`else
        if (par === 1'bx) rxd = 1'b1;
`endif
        rxd = stop;
        repeat (C) tick();
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0};
        rst = 1'b1; rxd = 1'b1; rd_ready = 1'b0; clr_overflow = 1'b0;
        repeat (3) tick();
        check("reset rd_valid", rd_valid, 0);
        check("reset rd_data", rd_data, 0);
        check("reset flags", {rd_ferr, rd_perr, overflow}, 0);
        check("reset level", level, 0);
        rst = 1'b0;
        repeat (3) tick();

        // exact push latency relative to the stop sample
        fork
            send_char(8'hA5, 1'b1, 1'b0);
            begin
                repeat (STOP_EDGE - 1) tick();
                check("latency pre level", level, 0);
                check("latency pre valid", rd_valid, 0);
                tick();
                check("latency valid", rd_valid, 1);
                check("latency level", level, 1);
                check("latency data", rd_data, 8'hA5);
                check("latency ferr", rd_ferr, 0);
            end
        join
        pop_one();
        check("pop level", level, 0);
        check("pop valid", rd_valid, 0);

        for (int v = 0; v < 5; v++) begin
            send_char(vecs[v].d, vecs[v].stop, vecs[v].par);
            rxd = 1'b1;
            repeat (4) tick();
            check("vec valid", rd_valid, 1);
            check("vec level", level, 1);
            check("vec data", rd_data, vecs[v].exp_d);
            check("vec ferr", rd_ferr, vecs[v].exp_ferr);
            check("vec perr", rd_perr, vecs[v].exp_perr);
            pop_one();
            check("vec drained", level, 0);
        end

        rxd = 1'b0;
        repeat (6) tick();
        rxd = 1'b1;
        repeat (20) tick();
        check("glitch level", level, 0);
        send_char(8'h3C, 1'b1, 1'b0);
        repeat (4) tick();
        check("post glitch data", rd_data, 8'h3C);
        check("post glitch level", level, 1);
        pop_one();

        send_char(8'h55, 1'b0, 1'b0);
        repeat (200) tick();
        check("break level", level, 1);
        check("break data", rd_data, 8'h55);
        check("break ferr", rd_ferr, 1);
        rxd = 1'b1;
        repeat (5) tick();
        check("break release level", level, 1);
        pop_one();
        send_char(8'h01, 1'b1, 1'b1);
        repeat (4) tick();
        check("after break data", rd_data, 8'h01);
        check("after break ferr", rd_ferr, 0);
        check("after break level", level, 1);
        pop_one();

        for (int i = 0; i < 5; i++) send_char(8'h10 + 8'(i), 1'b1, 1'b0);
        repeat (4) tick();
        check("ovf level", level, 4);
        check("ovf flag", overflow, 1);
        check("ovf head", rd_data, 8'h10);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf cleared", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            check("ovf entry", rd_data, 8'h10 + 8'(i));
            pop_one();
        end
        check("ovf drained", level, 0);

        for (int i = 0; i < 4; i++) send_char(8'h10 + 8'(i), 1'b1, 1'b0);
        fork
            send_char(8'h14, 1'b1, 1'b0);
            begin
                repeat (STOP_EDGE - 1) tick();
                check("full pre level", level, 4);
                rd_ready = 1'b1;
                tick();
                rd_ready = 1'b0;
                check("full pop level", level, 4);
                check("full pop overflow", overflow, 0);
                check("full pop head", rd_data, 8'h11);
            end
        join
        for (int i = 1; i < 5; i++) begin
            check("full pop entry", rd_data, 8'h10 + 8'(i));
            pop_one();
        end
        check("full pop drained", level, 0);

`ifdef UART_RX_CAPTURE_PARITY_EN
        send_char(8'h07, 1'b1, 1'b1);
        repeat (4) tick();
        check("parity good", rd_perr, 0);
        pop_one();
        send_char(8'h07, 1'b1, 1'b0);
        repeat (4) tick();
        check("parity bad", rd_perr, 1);
        check("parity bad data", rd_data, 8'h07);
        pop_one();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
